piso_shift_controller: RTL and testbench
========================================

Name: piso_shift_controller

Overview:
- Sequencer for an N-bit parallel-load / serial-out shift datapath.
- Accepts parallel words on a valid/ready handshake, then shifts them out one bit per `shift_en` tick, MSB- or LSB-first.
- Inserts a programmable idle gap between frames and flags frame completion.
- Sits between a word-producing client and a serial link or bit-stream consumer.

Parameters:
- N, 6, word width in bits; N >= 2.
- CNT_W, 3, bit/gap counter width; must satisfy 2^CNT_W > max(N-1, GAP).
- GAP, 0, idle ticks (ser_out = 0) inserted after each frame; 0 = none.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  client word valid.
- in_ready  out  1  controller can accept a word (high only in IDLE).
- in_data  in  N  parallel word, captured on handshake.
- lsb_first  in  1  bit order for the word being accepted; 1 = bit 0 first.
- shift_en  in  1  bit-rate tick; each high cycle consumes one bit or one gap slot.
- ser_out  out  1  serial bit, driven from a register.
- ser_active  out  1  high while a data bit is on ser_out (SHIFT state).
- frame_done  out  1  one-cycle pulse, registered, after the last bit is consumed.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; shift reg = 0; counters = 0.
  - ser_out = 0, ser_active = 0, frame_done = 0.
  - in_ready = 1 from the first cycle after release.
- States: IDLE, SHIFT, GAP. Outputs are decoded from the state register; in_ready = (state == IDLE).
- IDLE:
  - ser_out = 0.
  - Handshake = in_valid & in_ready at a posedge (cycle A).
  - On handshake: load the shift reg with in_data, bit-reversed if lsb_first = 1. lsb_first is sampled only at this edge.
  - Then bit_cnt = 0, state goes to SHIFT.
- SHIFT:
  - ser_out = shift_reg[N-1]; ser_active = 1.
  - A posedge with shift_en = 1 consumes the current bit. shift_en is honoured from the first SHIFT cycle.
  - If bit_cnt < N-1: shift left (fill 0), bit_cnt + 1.
  - If bit_cnt = N-1: clear the shift reg, set frame_done = 1 for one cycle. Next state is GAP if GAP > 0, else IDLE.
  - With shift_en = 0, state and ser_out hold.
- GAP:
  - ser_out = 0, ser_active = 0.
  - gap_cnt counts shift_en ticks; after GAP ticks, go to IDLE.
- Timing, shift_en tied high and GAP = 0:
  - Bits occupy cycles A+1 .. A+N.
  - frame_done and in_ready are both high in cycle A+N+1.
  - Minimum frame period is N+1 cycles (one-cycle accept bubble, by design).
- in_valid while not in IDLE: ignored. The client must hold in_data until the handshake.
- lsb_first or in_data changing mid-frame: no effect on the frame in progress.
- Reset mid-frame or mid-gap:
  - The frame is aborted immediately; outputs take reset values asynchronously.
  - No frame_done is issued.
  - The next accepted word transmits in full.
- Counters never wrap: bit_cnt is bounded by N-1 and gap_cnt by GAP, and both clear on exit.

Decomposition:
- Package piso_ctrl_pkg:
  - state enum {IDLE, SHIFT, GAP}.
  - Constant IDLE_LEVEL = 1'b0.
  - Helper function for the bit-reversal of an N-bit word.
- One sub-module, piso_shift_datapath: the N-bit register with load, shift-left and clear controls, plus the reversal mux. It has no FSM.
- All sequencing (FSM, bit_cnt, gap_cnt, frame_done) stays in piso_shift_controller.

Test Plan:
All scenarios use N = 6.
1. Reset release, then in_valid with 6'b101100, lsb_first = 0, shift_en = 1, GAP = 0.
   - ser_out = 1,0,1,1,0,0 in cycles A+1..A+6; ser_active high for exactly those cycles.
   - frame_done = 1 only in A+7; in_ready = 1 again in A+7.
2. Same word with lsb_first = 1.
   - ser_out = 0,0,1,1,0,1.
   - frame_done is one cycle after the 6th bit.
3. Word 6'b110001 with shift_en high every 3rd cycle.
   - Each bit is held for 3 cycles.
   - frame_done pulses once, in the cycle after the 6th shift_en tick.
4. GAP = 2, in_valid held high with 6'h3F then 6'h15.
   - Six 1s, then 2 gap ticks with ser_out = 0 and in_ready = 0, then IDLE/handshake.
   - Then 0,1,0,1,0,1; no word lost or duplicated.
5. rst_n pulsed low after the 3rd bit of 6'h2A.
   - ser_out, ser_active and frame_done go to 0 immediately; no frame_done for the aborted word.
   - Next word 6'h07 gives 0,0,0,1,1,1.
6. lsb_first toggled, and in_valid with new data, during SHIFT.
   - Current frame bits are unchanged.
   - The new word is accepted only when in_ready returns, and its order follows lsb_first at that edge.

Source files
------------

// File: rtl/piso_ctrl_pkg.sv
// Shared types and helpers for the PISO shift controller.
package piso_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2
    } state_e;

    // Level driven on ser_out whenever no data bit is on the line.
    localparam logic IDLE_LEVEL = 1'b0;

    // Widest word the reversal helper supports; N must not exceed this.
    localparam int unsigned MAX_W = 64;

    // Reverse the low `width` bits of `word`; upper result bits are zero.
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] word,
                                                     input int unsigned      width);
        logic [MAX_W-1:0] rev;
        rev = {<<{word}};
        return rev >> (MAX_W - width);
    endfunction

endpackage

// File: rtl/piso_shift_datapath.sv
// N-bit parallel-load / shift-left register with optional bit reversal on load.
module piso_shift_datapath
    import piso_ctrl_pkg::*;
#(
    parameter int unsigned N = 6
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic         clear_i,
    input  logic         lsb_first_i,
    input  logic [N-1:0] par_i,
    output logic         msb_o
);

    logic [N-1:0] shift_q;
    logic [N-1:0] shift_d;
    logic [N-1:0] load_word;

    // Select load word order and compute the register's next value.
    always_comb begin
        load_word = lsb_first_i ? N'(bit_reverse(MAX_W'(par_i), N)) : par_i;
        shift_d   = shift_q;
        if (clear_i) begin
            shift_d = '0;
        end else if (load_i) begin
            shift_d = load_word;
        end else if (shift_i) begin
            shift_d = {shift_q[N-2:0], 1'b0};
        end
    end

    // Shift register state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign msb_o = shift_q[N-1];

endmodule

// File: rtl/piso_shift_controller.sv
// Sequencer for a parallel-in / serial-out link: accept, shift out, optional idle gap.
module piso_shift_controller
    import piso_ctrl_pkg::*;
#(
    parameter int unsigned N     = 6,
    parameter int unsigned CNT_W = 3,
    parameter int unsigned GAP   = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         lsb_first,
    input  logic         shift_en,
    output logic         ser_out,
    output logic         ser_active,
    output logic         frame_done
);

    localparam logic [CNT_W-1:0] LastBit = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] LastGap = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             dp_load, dp_shift, dp_clear;
    logic             dp_msb;

    piso_shift_datapath #(
        .N (N)
    ) u_datapath (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .load_i      (dp_load),
        .shift_i     (dp_shift),
        .clear_i     (dp_clear),
        .lsb_first_i (lsb_first),
        .par_i       (in_data),
        .msb_o       (dp_msb)
    );

    // Next-state, counter and datapath control decode.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        frame_done_d = 1'b0;
        dp_load      = 1'b0;
        dp_shift     = 1'b0;
        dp_clear     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // in_ready is implied by being in this state.
                if (in_valid) begin
                    dp_load   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (shift_en) begin
                    if (bit_cnt_q == LastBit) begin
                        dp_clear     = 1'b1;
                        bit_cnt_d    = '0;
                        gap_cnt_d    = '0;
                        frame_done_d = 1'b1;
                        if (GAP > 0) begin
                            state_d = StGap;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        dp_shift  = 1'b1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            StGap: begin
                if (shift_en) begin
                    if (gap_cnt_q == LastGap) begin
                        gap_cnt_d = '0;
                        state_d   = StIdle;
                    end else begin
                        gap_cnt_d = gap_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
            end
        endcase
    end

    // State, counters and the registered frame_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Outputs decoded from registered state only.
    assign in_ready   = (state_q == StIdle);
    assign ser_active = (state_q == StShift);
    assign ser_out    = ser_active ? dp_msb : IDLE_LEVEL;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_piso_shift_controller.sv
// Directed self-checking bench: one instance with no gap, one with a two-tick gap.
module tb_piso_shift_controller;

    localparam int unsigned N = 6;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         lsb_first = 1'b0;
    logic         shift_en  = 1'b0;
    logic [N-1:0] in_data   = '0;

    logic in_ready0, ser_out0, ser_active0, frame_done0;
    logic in_ready2, ser_out2, ser_active2, frame_done2;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    piso_shift_controller #(.N(N), .CNT_W(3), .GAP(0)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready0),
        .in_data    (in_data),
        .lsb_first  (lsb_first),
        .shift_en   (shift_en),
        .ser_out    (ser_out0),
        .ser_active (ser_active0),
        .frame_done (frame_done0)
    );

    piso_shift_controller #(.N(N), .CNT_W(3), .GAP(2)) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready2),
        .in_data    (in_data),
        .lsb_first  (lsb_first),
        .shift_en   (shift_en),
        .ser_out    (ser_out2),
        .ser_active (ser_active2),
        .frame_done (frame_done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Frame on the no-gap instance; each bit held `hold` cycles, shift_en on the last.
    task automatic check_frame0(input string tag, input logic [N-1:0] bits, input int hold);
        for (int i = 0; i < N; i++) begin
            for (int h = 0; h < hold; h++) begin
                shift_en = (h == hold - 1);
                check($sformatf("%s bit%0d ser_out", tag, i), ser_out0, bits[N-1-i]);
                check($sformatf("%s bit%0d active", tag, i), ser_active0, 1);
                check($sformatf("%s bit%0d done", tag, i), frame_done0, 0);
                check($sformatf("%s bit%0d ready", tag, i), in_ready0, 0);
                tick();
            end
        end
        check({tag, " done pulse"}, frame_done0, 1);
        check({tag, " ready back"}, in_ready0, 1);
        check({tag, " active low"}, ser_active0, 0);
        check({tag, " line idle"}, ser_out0, 0);
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        check("rst ser_out", ser_out0, 0);
        check("rst active", ser_active0, 0);
        check("rst done", frame_done0, 0);
        rst_n = 1'b1;
        tick();
        check("rst ready", in_ready0, 1);

        // 1: MSB-first, shift_en tied high
        in_data = 6'b101100; lsb_first = 1'b0; shift_en = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_frame0("s1", 6'b101100, 1);
        tick();
        check("s1 pulse one cycle", frame_done0, 0);

        // 2: same word LSB-first; lsb_first dropped right after the handshake
        lsb_first = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; lsb_first = 1'b0;
        check_frame0("s2", 6'b001101, 1);

        // 3: shift_en every third cycle
        in_data = 6'b110001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_frame0("s3", 6'b110001, 3);
        shift_en = 1'b0;
        tick();
        check("s3 pulse one cycle", frame_done0, 0);

        // 6: order/data changes mid-frame only affect the next accepted word
        in_data = 6'b100110; lsb_first = 1'b0; shift_en = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i == 2) begin
                lsb_first = 1'b1; in_valid = 1'b1; in_data = 6'b110100;
            end
            check($sformatf("s6 cur bit%0d", i), ser_out0, (i == 0 || i == 3 || i == 4));
            check($sformatf("s6 cur ready%0d", i), in_ready0, 0);
            tick();
        end
        check("s6 done", frame_done0, 1);
        check("s6 ready", in_ready0, 1);
        tick();
        in_valid = 1'b0; lsb_first = 1'b0;
        check_frame0("s6 new", 6'b001011, 1);

        // 4: GAP = 2 with in_valid held across two words
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("s4 ready", in_ready2, 1);
        in_data = 6'h3F; in_valid = 1'b1; shift_en = 1'b1;
        tick();
        in_data = 6'h15;
        for (int i = 0; i < N; i++) begin
            check($sformatf("s4 w0 bit%0d", i), ser_out2, 1);
            check($sformatf("s4 w0 ready%0d", i), in_ready2, 0);
            tick();
        end
        check("s4 gap0 done", frame_done2, 1);
        check("s4 gap0 line", ser_out2, 0);
        check("s4 gap0 active", ser_active2, 0);
        check("s4 gap0 ready", in_ready2, 0);
        tick();
        check("s4 gap1 line", ser_out2, 0);
        check("s4 gap1 ready", in_ready2, 0);
        check("s4 gap1 done", frame_done2, 0);
        tick();
        check("s4 idle ready", in_ready2, 1);
        check("s4 idle line", ser_out2, 0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            check($sformatf("s4 w1 bit%0d", i), ser_out2, (i % 2));
            check($sformatf("s4 w1 active%0d", i), ser_active2, 1);
            tick();
        end
        check("s4 w1 done", frame_done2, 1);
        check("s4 w1 gap ready", in_ready2, 0);
        tick();
        tick();
        check("s4 end ready", in_ready2, 1);
        tick();
        check("s4 no dup", ser_active2, 0);

        // 5: reset in the middle of 6'h2A, then 6'h07 in full
        check("s5 ready", in_ready0, 1);
        in_data = 6'h2A; lsb_first = 1'b0; shift_en = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("s5 abort bit%0d", i), ser_out0, (i % 2 == 0));
            if (i < 2) tick();
        end
        rst_n = 1'b0;
        #1;
        check("s5 async ser_out", ser_out0, 0);
        check("s5 async active", ser_active0, 0);
        check("s5 async done", frame_done0, 0);
        check("s5 async ready", in_ready0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("s5 no done%0d", i), frame_done0, 0);
            check($sformatf("s5 quiet%0d", i), ser_active0, 0);
        end
        in_data = 6'h07; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_frame0("s5 next", 6'b000111, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
